// File: rtl/sram_pkg.sv
// Shared types and helpers for the masked 1RW SRAM: FSM state, lane-mask
// expansion and the geometry check evaluated at elaboration.
package sram_pkg;

    typedef enum logic [0:0] {
        SRAM_CLEAR = 1'b0,
        SRAM_READY = 1'b1
    } sram_state_e;

    // Widest word the lane-expand helper can serve; instances above this fail the geometry check.
    localparam int SRAM_MAX_DATA_W = 1024;
    localparam int SRAM_IDX_W      = 10;

    function automatic bit sram_cfg_ok(input int data_w, input int mask_gran, input int depth);
        bit ok;
        ok = 1'b0;
        if (mask_gran > 32'sd0) begin
            ok = (data_w >= mask_gran) && ((data_w % mask_gran) == 32'sd0) &&
                 (data_w <= SRAM_MAX_DATA_W) && (depth >= 32'sd2);
        end
        return ok;
    endfunction

    // Bit i of the result copies lane bit (i / gran) of the mask.
    function automatic logic [SRAM_MAX_DATA_W-1:0] sram_lane_expand(
        input logic [SRAM_MAX_DATA_W-1:0] mask,
        input int                         gran
    );
        logic [SRAM_MAX_DATA_W-1:0] bits;
        logic [SRAM_IDX_W-1:0]      lane;
        bits = '0;
        for (int i = 32'sd0; i < SRAM_MAX_DATA_W; i++) begin
            lane    = SRAM_IDX_W'(i / gran);
            bits[i] = mask[lane];
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_clear_sweeper.sv
// CLEAR/READY controller: walks every address once after reset issuing
// zero-writes, then raises ready and stays there until the next reset.
module sram_clear_sweeper
    import sram_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sram_state_e       state_r;
    sram_state_e       state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    logic              ready_r;

    // State, sweep counter and ready flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SRAM_CLEAR;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == SRAM_READY);
        end
    end

    // Next-state and sweep-address advance.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            SRAM_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = SRAM_READY;
                    cnt_s   = cnt_r;
                end else begin
                    state_s = SRAM_CLEAR;
                    cnt_s   = cnt_r + 1'b1;
                end
            end
            SRAM_READY: begin
                state_s = SRAM_READY;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = SRAM_CLEAR;
                cnt_s   = '0;
            end
        endcase
    end

    assign clr_we   = (state_r == SRAM_CLEAR);
    assign clr_addr = cnt_r;
    assign ready    = ready_r;

endmodule

// File: rtl/sram_1rw_mask_ext.sv
// Parametrised single-port byte-lane-masked SRAM with post-reset clear sweep,
// ready flag and read-valid strobe. Define SRAM_OUTREG_EN for a 2-cycle read.
module sram_1rw_mask_ext
    import sram_pkg::*;
#(
    parameter  int DATA_W    = 300,
    parameter  int DEPTH     = 1024,
    parameter  int MASK_GRAN = 30,
    localparam int MASK_W    = DATA_W / MASK_GRAN,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready
);

    localparam bit              CFG_OK    = sram_cfg_ok(DATA_W, MASK_GRAN, DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if (!CFG_OK) begin : g_cfg_err
        $error("sram_1rw_mask_ext: DATA_W must be a multiple of MASK_GRAN and DEPTH >= 2");
    end

    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              ready_s;
    logic              in_range_s;
    logic              user_wr_s;
    logic              user_rd_s;
    logic [DATA_W-1:0] bit_mask_s;
    logic [DATA_W-1:0] rd_word_s;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              rd_valid_r;
    logic [DATA_W-1:0] rd_data_r;

    sram_clear_sweeper #(
        .DEPTH (DEPTH)
    ) u_sweeper (
        .clk      (RW0_clk),
        .rst      (RW0_rst),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s),
        .ready    (ready_s)
    );

    assign in_range_s = ({1'b0, RW0_addr} < DEPTH_EXT);
    assign user_wr_s  = ready_s & RW0_en & RW0_wmode & in_range_s;
    assign user_rd_s  = ready_s & RW0_en & ~RW0_wmode;
    assign bit_mask_s = DATA_W'(sram_lane_expand(SRAM_MAX_DATA_W'(RW0_wmask), MASK_GRAN));
    assign rd_word_s  = in_range_s ? mem_r[RW0_addr] : '0;

    // Array write port: sweep zero-writes take priority, user writes merge by lane.
    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst && clr_we_s) begin
            mem_r[clr_addr_s] <= '0;
        end else if (!RW0_rst && user_wr_s) begin
            mem_r[RW0_addr] <= (mem_r[RW0_addr] & ~bit_mask_s) | (RW0_wdata & bit_mask_s);
        end
    end

    // First read stage; data holds between reads so writes never disturb it.
    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else if (user_rd_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= rd_word_s;
        end else begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= rd_data_r;
        end
    end

`ifdef SRAM_OUTREG_EN
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;

    // Optional output retiming stage.
    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (rd_valid_r) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rd_data_r;
        end else begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end
    end

    assign RW0_rvalid = out_valid_r;
    assign RW0_rdata  = out_data_r;
`else
    assign RW0_rvalid = rd_valid_r;
    assign RW0_rdata  = rd_data_r;
`endif

    assign RW0_ready = ready_s;

endmodule

// File: tb/tb_sram_1rw_mask_ext.sv
// Scoreboard bench for sram_1rw_mask_ext: random and directed traffic against
// a lane-level array model; a monitor pops expected reads on every rvalid.
module tb_sram_1rw_mask_ext;

    localparam int DATA_W    = 300;
    localparam int DEPTH     = 1024;
    localparam int MASK_GRAN = 30;
    localparam int MASK_W    = DATA_W / MASK_GRAN;
    localparam int ADDR_W    = $clog2(DEPTH);
`ifdef SRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              RW0_rst = 1'b0;
    logic [ADDR_W-1:0] RW0_addr = '0;
    logic              RW0_en = 1'b0;
    logic              RW0_wmode = 1'b0;
    logic [MASK_W-1:0] RW0_wmask = '0;
    logic [DATA_W-1:0] RW0_wdata = '0;
    logic [DATA_W-1:0] RW0_rdata;
    logic              RW0_rvalid;
    logic              RW0_ready;

    sram_1rw_mask_ext #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .MASK_GRAN (MASK_GRAN)
    ) dut (
        .RW0_clk    (clk),
        .RW0_rst    (RW0_rst),
        .RW0_addr   (RW0_addr),
        .RW0_en     (RW0_en),
        .RW0_wmode  (RW0_wmode),
        .RW0_wmask  (RW0_wmask),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (RW0_rdata),
        .RW0_rvalid (RW0_rvalid),
        .RW0_ready  (RW0_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] hold_exp = '0;
    bit                mon_on = 1'b0;
    int                cyc = 0;
    int                vectors = 0;
    int                miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Monitor: every rvalid must match the oldest outstanding read, on its due cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (RW0_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rvalid_cycle", cyc, e.due);
                    chk("rdata", RW0_rdata, e.data);
                    hold_exp = e.data;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("missing_rvalid", cyc, exp_q[0].due + 1);
                    void'(exp_q.pop_front());
                end
                chk("rdata_hold", RW0_rdata, hold_exp);
            end
        end
    end

    // Apply one cycle of request inputs; the model follows only requests the DUT accepts.
    task automatic drive(input bit en, input bit wm, input logic [ADDR_W-1:0] a,
                         input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d, input bit acc);
        exp_t e;
        RW0_en    = en;
        RW0_wmode = wm;
        RW0_addr  = a;
        RW0_wmask = m;
        RW0_wdata = d;
        if (en && acc) begin
            if (wm) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (m[l]) model[a][l*MASK_GRAN +: MASK_GRAN] = d[l*MASK_GRAN +: MASK_GRAN];
                end
            end else begin
                e.data = model[a];
                e.due  = cyc + LAT;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic wr(input int a, input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
        drive(1'b1, 1'b1, ADDR_W'(a), m, d, 1'b1);
    endtask

    task automatic rd(input int a);
        drive(1'b1, 1'b0, ADDR_W'(a), '0, '0, 1'b1);
    endtask

    // One-cycle reset (optionally with a read sampled on the same edge), then time the sweep.
    task automatic reset_sweep(input bit with_read);
        int n;
        mon_on    = 1'b0;
        RW0_rst   = 1'b1;
        RW0_en    = with_read;
        RW0_wmode = 1'b0;
        RW0_addr  = ADDR_W'(5);
        @(negedge clk);
        RW0_en = 1'b0;
        chk("reset_ready", RW0_ready, 0);
        chk("reset_rvalid", RW0_rvalid, 0);
        chk("reset_rdata", RW0_rdata, 0);
        hold_exp = '0;
        RW0_rst  = 1'b0;
        mon_on   = 1'b1;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        n = 0;
        while (RW0_ready !== 1'b1 && n < 3 * DEPTH) begin
            if (n == 10)      drive(1'b1, 1'b1, ADDR_W'(7), '1, DATA_W'(1), 1'b0);
            else if (n == 20) drive(1'b1, 1'b0, ADDR_W'(7), '0, '0, 1'b0);
            else              drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
            n++;
        end
        chk("sweep_cycles", n, DEPTH);
    endtask

    initial begin
        logic [MASK_W-1:0] m;
        logic [DATA_W-1:0] d;

        reset_sweep(1'b0);
        rd(0); rd(511); rd(1023); rd(7);
        idle(LAT + 2);

        // Masked write: full-lane ones, then clear lane 1 only.
        wr(5, '1, '1);
        wr(5, MASK_W'(2), '0);
        rd(5);
        idle(4);
        wr(5, '1, rnd_data());
        idle(3);
        rd(5);
        idle(LAT + 1);

        // Zero-mask write is a no-op.
        wr(5, '0, rnd_data());
        rd(5);
        idle(LAT + 1);

        // Back-to-back reads after distinct writes.
        wr(1, '1, rnd_data());
        wr(2, '1, rnd_data());
        wr(3, '1, rnd_data());
        rd(1); rd(2); rd(3);
        idle(LAT + 2);

        // Random mixed traffic over a small address window plus occasional far addresses.
        for (int i = 0; i < 400; i++) begin
            m = MASK_W'($urandom());
            d = rnd_data();
            drive(($urandom_range(3, 0) != 0), $urandom_range(1, 0),
                  ($urandom_range(7, 0) == 0) ? ADDR_W'($urandom_range(DEPTH - 1, 0))
                                              : ADDR_W'($urandom_range(15, 0)),
                  m, d, 1'b1);
        end
        idle(LAT + 2);

        // Reset sampled together with a read: the read must vanish and the sweep restart.
        reset_sweep(1'b1);
        rd(5); rd(7); rd(1);
        idle(LAT + 2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_1rw_mask_ext.md
# sram_1rw_mask_ext

Parametrised single-port, byte-lane-masked synchronous SRAM model. It is the generalised successor to the fixed-geometry 1RW array macros and is used for cache data and tag arrays, with width, depth and mask granularity set per instance. Over the fixed macros it adds three things: a self-clearing sweep after reset, a ready indication, and a read-valid strobe with held read data.

## Interface
- DATA_W, 300, data width in bits
- DEPTH, 1024, number of words; any value ≥ 2
- MASK_GRAN, 30, bits per write-mask lane; DATA_W % MASK_GRAN ≠ 0 is an elaboration error
- MASK_W, DATA_W/MASK_GRAN, derived; not overridable
- ADDR_W, $clog2(DEPTH), derived; not overridable
- RW0_clk  input  1  sole clock; all state updates on rising edge
- RW0_rst  input  1  reset; **synchronous, active-high**
- RW0_addr  input  ADDR_W  word address; values ≥ DEPTH are ignored (no write; a read returns 0)
- RW0_en  input  1  request strobe
- RW0_wmode  input  1  1 = write, 0 = read
- RW0_wmask  input  MASK_W  lane i enables bits [i*MASK_GRAN +: MASK_GRAN]
- RW0_wdata  input  DATA_W  write data
- RW0_rdata  output  DATA_W  read data; reset 0
- RW0_rvalid  output  1  one-cycle pulse marking fresh RW0_rdata; reset 0
- RW0_ready  output  1  1 = requests accepted; reset 0

## Operation
- States: CLEAR and READY. Reset forces CLEAR, clears the sweep counter, RW0_rdata, RW0_rvalid and RW0_ready.
- CLEAR: each cycle, write all-zero to ram[cnt] (full width, mask ignored), then cnt++. When cnt == DEPTH-1 is written, go to READY. RW0_ready = 0 throughout.
- In CLEAR, any RW0_en is dropped: no write, no rvalid.
- READY: RW0_ready = 1.
  - Write (en & wmode): write only the lanes with mask set; other lanes keep their old contents. A write with wmask == 0 is a no-op.
  - Read (en & !wmode): capture ram[addr] into the read pipeline and raise rvalid at the read latency.
- RW0_rdata holds the last read value until the next read completes. Writes never disturb RW0_rdata, including a write to the address last read.
- Single port: a read and a write in the same cycle are impossible by construction.
- Reset mid-operation (either state):
  - the in-flight read is cancelled, so rvalid stays 0;
  - the sweep restarts from address 0;
  - memory contents are overwritten again by the sweep.

## Timing
- Clear sweep: DEPTH cycles. With RW0_rst low at edge 0, zeros go to addresses 0..DEPTH-1 on edges 0..DEPTH-1. RW0_ready is 1 after edge DEPTH-1.
- Read latency, request edge to rdata/rvalid valid: 1 cycle without the output register, 2 cycles with it.
- Reads are fully pipelined: back-to-back reads give back-to-back rvalid pulses in issue order.
- Write latency: 1 cycle. A read of the same address issued on the next cycle returns the new data.
- Throughput: one request per cycle in READY.

## Configuration
- Macro SRAM_OUTREG_EN.
- Defined: adds an extra register stage on rdata and rvalid, for timing closure on wide arrays. Read latency is 2. Reset also clears the extra stage.
- Undefined: read latency is 1, with rdata driven straight from the first capture register.
- Clear behaviour, ready timing and write behaviour are identical in both builds.

## Structure
- Shared package sram_pkg holds:
  - the state typedef {SRAM_CLEAR, SRAM_READY};
  - a lane-expand function that turns MASK_W into a DATA_W bit mask;
  - the localparam check used for the DATA_W/MASK_GRAN elaboration assertion.
- One sub-module, sram_clear_sweeper: the CLEAR/READY FSM plus the sweep address counter. It outputs clr_we, clr_addr and ready. The top muxes clear writes against user writes.

## Test plan
- Post-reset sweep: pulse RW0_rst for 1 cycle, DEPTH=1024. Expect RW0_ready = 0 for 1024 cycles, then 1. Reading addresses 0, 511 and 1023 then returns 0.
- Masked write: write 0x3FFFFFFF to all lanes of address 5, then write wmask=10'b0000000010 with wdata all-zero. A read of address 5 returns lane 1 = 0 and all other lanes = 0x3FFFFFFF.
- Read latency and hold:
  - Read address 5, then idle 4 cycles.
  - Expect rvalid high for exactly 1 cycle, at +1 (+2 with SRAM_OUTREG_EN).
  - rdata is unchanged through the idle cycles and through a following write to address 5.
- Back-to-back reads: write distinct values to addresses 1, 2, 3, then issue reads in consecutive cycles. Expect 3 consecutive rvalid pulses returning the values in order.
- Request during CLEAR: assert en/wmode to address 7 with data 0x1 at cycle 10 of the sweep. After ready, a read of address 7 returns 0 and no rvalid occurred during the sweep.
- Reset mid-read: issue a read, then assert RW0_rst on the next edge. Expect no rvalid, rdata = 0 and ready = 0. The sweep restarts and takes a full 1024 cycles.
